// File: rtl/alu_wide_seq_pkg.sv
// alu_wide_seq_pkg
//   Shared definitions for the multi-byte ALU sequencer.
//   - Op codes understood by the 8-bit ALU (add/sub/inc/dec).
//   - Sequencer state encoding.
//   - Helper that classifies an op as subtract-like.
package alu_wide_seq_pkg;

    // ALU op codes, shared with the byte ALU
    localparam logic [2:0] OpAdd = 3'd0;
    localparam logic [2:0] OpSub = 3'd1;
    localparam logic [2:0] OpInc = 3'd2;
    localparam logic [2:0] OpDec = 3'd3;

    typedef enum logic [1:0] {
        StIdle,
        StBase,
        StFix,
        StDone
    } state_e;

    // sub and dec both run as subtract chains after normalisation
    function automatic logic op_is_sub(input logic [2:0] op);
        return (op == OpSub) || (op == OpDec);
    endfunction

endpackage

// File: rtl/alu_wide_seq.sv
// alu_wide_seq
//   Multi-byte add/sub/inc/dec sequencer around an external 8-bit combinational ALU.
//   Bytes are processed LSB first. The ALU has no carry-in, so a carry/borrow into a byte
//   costs one extra inc/dec pass (FIX) on that byte's partial result.
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start_valid/ready   request handshake; ready only in IDLE
//   op, a, b            operation and operands, sampled on accept
//   alu_operation/A/B   drive to the byte ALU (0 outside BASE/FIX)
//   alu_C, alu_flags_*  byte ALU result and flags
//   result, flags_c/z   wide result and flags, loaded when entering DONE, held otherwise
//   done, err           one-cycle completion pulse; err marks an illegal op code
module alu_wide_seq
    import alu_wide_seq_pkg::*;
#(
    parameter int unsigned N_BYTES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start_valid,
    output logic                 start_ready,
    input  logic [2:0]           op,
    input  logic [8*N_BYTES-1:0] a,
    input  logic [8*N_BYTES-1:0] b,
    output logic [2:0]           alu_operation,
    output logic [7:0]           alu_A,
    output logic [7:0]           alu_B,
    input  logic [7:0]           alu_C,
    input  logic                 alu_flags_c,
    input  logic                 alu_flags_z,
    output logic [8*N_BYTES-1:0] result,
    output logic                 flags_c,
    output logic                 flags_z,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned W  = 8 * N_BYTES;
    localparam int unsigned IW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
    localparam logic [IW-1:0] LastIdx = IW'(N_BYTES - 1);

    typedef logic [N_BYTES-1:0][7:0] bytes_t;

    state_e         state_q, state_d;
    bytes_t         a_q, a_d;
    bytes_t         b_q, b_d;
    bytes_t         wbuf_q, wbuf_d;
    logic           sub_q, sub_d;
    logic           bad_q, bad_d;
    logic [IW-1:0]  i_q, i_d;
    logic           cy_q, cy_d;
    logic           t_q, t_d;
    logic [7:0]     part_q, part_d;
    logic           zacc_q, zacc_d;
    logic [W-1:0]   result_q, result_d;
    logic           fc_q, fc_d;
    logic           fz_q, fz_d;

    logic           commit;
    logic           commit_cy;
    logic           alu_cy;

    // Carry-out for add chains, borrow for sub chains (ALU reports NOT borrow)
    assign alu_cy = sub_q ? ~alu_flags_c : alu_flags_c;

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            wbuf_q   <= '0;
            sub_q    <= 1'b0;
            bad_q    <= 1'b0;
            i_q      <= '0;
            cy_q     <= 1'b0;
            t_q      <= 1'b0;
            part_q   <= '0;
            zacc_q   <= 1'b0;
            result_q <= '0;
            fc_q     <= 1'b0;
            fz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            wbuf_q   <= wbuf_d;
            sub_q    <= sub_d;
            bad_q    <= bad_d;
            i_q      <= i_d;
            cy_q     <= cy_d;
            t_q      <= t_d;
            part_q   <= part_d;
            zacc_q   <= zacc_d;
            result_q <= result_d;
            fc_q     <= fc_d;
            fz_q     <= fz_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        wbuf_d    = wbuf_q;
        sub_d     = sub_q;
        bad_d     = bad_q;
        i_d       = i_q;
        cy_d      = cy_q;
        t_d       = t_q;
        part_d    = part_q;
        zacc_d    = zacc_q;
        result_d  = result_q;
        fc_d      = fc_q;
        fz_d      = fz_q;
        commit    = 1'b0;
        commit_cy = cy_q;

        unique case (state_q)
            StIdle: begin
                if (start_valid) begin
                    a_d = a;
                    // inc/dec become add/sub of a one in byte 0
                    if (op == OpInc || op == OpDec) begin
                        b_d    = '0;
                        b_d[0] = 8'h01;
                    end else begin
                        b_d = b;
                    end
                    sub_d   = op_is_sub(op);
                    bad_d   = op[2];
                    i_d     = '0;
                    cy_d    = 1'b0;
                    zacc_d  = 1'b1;
                    state_d = op[2] ? StDone : StBase;
                end
            end
            StBase: begin
                part_d = alu_C;
                t_d    = alu_cy;
                if (cy_q) begin
                    state_d = StFix;
                end else begin
                    commit    = 1'b1;
                    commit_cy = alu_cy;
                end
            end
            StFix: begin
                // Either the base pass or the fix-up pass can produce the outgoing carry
                commit    = 1'b1;
                commit_cy = t_q | alu_cy;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (commit) begin
            wbuf_d[i_q] = alu_C;
            zacc_d      = zacc_q & alu_flags_z;
            cy_d        = commit_cy;
            if (i_q == LastIdx) begin
                state_d  = StDone;
                // Load the visible result on entry to DONE so it is valid with the pulse
                result_d = wbuf_d;
                fz_d     = zacc_d;
                fc_d     = sub_q ? ~commit_cy : commit_cy;
            end else begin
                i_d     = i_q + 1'b1;
                state_d = StBase;
            end
        end
    end

    // Outputs
    always_comb begin
        start_ready   = (state_q == StIdle);
        done          = (state_q == StDone);
        err           = (state_q == StDone) & bad_q;
        alu_operation = 3'd0;
        alu_A         = 8'h00;
        alu_B         = 8'h00;
        unique case (state_q)
            StBase: begin
                alu_operation = sub_q ? OpSub : OpAdd;
                alu_A         = a_q[i_q];
                alu_B         = b_q[i_q];
            end
            StFix: begin
                alu_operation = sub_q ? OpDec : OpInc;
                alu_A         = part_q;
            end
            default: begin
                alu_operation = 3'd0;
            end
        endcase
    end

    assign result  = result_q;
    assign flags_c = fc_q;
    assign flags_z = fz_q;

endmodule
